// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: time-shares one combinational ALU between two requesters.
// Accepts one operation at a time, registers the ALU operands on the grant edge,
// captures the ALU result one cycle later and returns it with the requester ID
// over a valid/ready response channel.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (requester 0 always wins a tie);
// when undefined, ties are resolved round-robin.

module alu_share_arbiter #(
    parameter int unsigned W   = 32,
    parameter int unsigned OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,

    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_rd1,
    input  logic [W-1:0]   req0_rd2,
    input  logic [W-1:0]   req0_simm,
    input  logic           req0_imm_sel,
    input  logic [OPW-1:0] req0_op,

    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_rd1,
    input  logic [W-1:0]   req1_rd2,
    input  logic [W-1:0]   req1_simm,
    input  logic           req1_imm_sel,
    input  logic [OPW-1:0] req1_op,

    output logic [W-1:0]   alu_in1,
    output logic [W-1:0]   alu_in2,
    output logic [OPW-1:0] alu_op,
    input  logic [W-1:0]   alu_result,

    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [W-1:0]   rsp_data,

    output logic           busy
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e         r_state;
    state_e         w_state_next;

    logic           r_last_grant;
    logic [W-1:0]   r_alu_in1;
    logic [W-1:0]   r_alu_in2;
    logic [OPW-1:0] r_alu_op;
    logic           r_rsp_valid;
    logic           r_rsp_id;
    logic [W-1:0]   r_rsp_data;

    logic           w_any_valid;
    logic           w_pick1;
    logic           w_grant;
    logic [W-1:0]   w_sel_rd1;
    logic [W-1:0]   w_sel_in2;
    logic [OPW-1:0] w_sel_op;

    // Arbitration: decide which requester would win and whether a grant happens now
    always_comb begin
        w_any_valid = req0_valid | req1_valid;
        w_pick1     = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            w_pick1 = 1'b0;
`else
            // Tie goes to whichever requester was not granted last
            w_pick1 = ~r_last_grant;
`endif
        end else begin
            w_pick1 = req1_valid;
        end
        // Ready is suppressed while reset is held, even if state has not yet cleared
        w_grant    = rst_n & (r_state == StIdle) & w_any_valid;
        req0_ready = w_grant & ~w_pick1;
        req1_ready = w_grant & w_pick1;
        busy       = rst_n & (r_state != StIdle);
    end

    // Operand selection from the winning requester, including immediate mux
    always_comb begin
        w_sel_rd1 = req0_rd1;
        w_sel_in2 = req0_imm_sel ? req0_simm : req0_rd2;
        w_sel_op  = req0_op;
        if (w_pick1) begin
            w_sel_rd1 = req1_rd1;
            w_sel_in2 = req1_imm_sel ? req1_simm : req1_rd2;
            w_sel_op  = req1_op;
        end
    end

    // Next-state logic for the IDLE -> EXEC -> RESP sequence
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (w_grant) w_state_next = StExec;
            StExec: w_state_next = StResp;
            StResp: if (rsp_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand capture on grant, result capture in EXEC, response handshake in RESP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_alu_in1    <= '0;
            r_alu_in2    <= '0;
            r_alu_op     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= '0;
        end else begin
            if (w_grant) begin
                r_alu_in1    <= w_sel_rd1;
                r_alu_in2    <= w_sel_in2;
                r_alu_op     <= w_sel_op;
                r_rsp_id     <= w_pick1;
                r_last_grant <= w_pick1;
            end
            if (r_state == StExec) begin
                r_rsp_data  <= alu_result;
                r_rsp_valid <= 1'b1;
            end
            if ((r_state == StResp) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign alu_in1   = r_alu_in1;
    assign alu_in2   = r_alu_in2;
    assign alu_op    = r_alu_op;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: directed vectors, scoreboard queue of expected
// responses checked by an independent monitor, plus direct timing/state checks.

module tb_alu_share_arbiter;

    localparam int unsigned W   = 32;
    localparam int unsigned OPW = 4;

    localparam logic [OPW-1:0] OP_ADD = 4'd0;
    localparam logic [OPW-1:0] OP_SUB = 4'd1;
    localparam logic [OPW-1:0] OP_AND = 4'd2;
    localparam logic [OPW-1:0] OP_OR  = 4'd3;
    localparam logic [OPW-1:0] OP_XOR = 4'd4;

    logic           clk;
    logic           rst_n;
    logic           req0_valid, req0_ready, req0_imm_sel;
    logic [W-1:0]   req0_rd1, req0_rd2, req0_simm;
    logic [OPW-1:0] req0_op;
    logic           req1_valid, req1_ready, req1_imm_sel;
    logic [W-1:0]   req1_rd1, req1_rd2, req1_simm;
    logic [OPW-1:0] req1_op;
    logic [W-1:0]   alu_in1, alu_in2, alu_result;
    logic [OPW-1:0] alu_op;
    logic           rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0]   rsp_data;
    logic           busy;

    int n_err;
    int n_chk;
    int cyc;
    int both_ready_cnt;

    typedef struct packed {
        logic         id;
        logic [W-1:0] data;
    } rsp_t;

    rsp_t sb_q[$];
    int   gnt_id_q[$];
    int   gnt_cyc_q[$];

    alu_share_arbiter #(
        .W   (W),
        .OPW (OPW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_rd1     (req0_rd1),
        .req0_rd2     (req0_rd2),
        .req0_simm    (req0_simm),
        .req0_imm_sel (req0_imm_sel),
        .req0_op      (req0_op),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_rd1     (req1_rd1),
        .req1_rd2     (req1_rd2),
        .req1_simm    (req1_simm),
        .req1_imm_sel (req1_imm_sel),
        .req1_op      (req1_op),
        .alu_in1      (alu_in1),
        .alu_in2      (alu_in2),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .busy         (busy)
    );

    // Combinational ALU model
    always_comb begin
        alu_result = '0;
        case (alu_op)
            OP_ADD:  alu_result = alu_in1 + alu_in2;
            OP_SUB:  alu_result = alu_in1 - alu_in2;
            OP_AND:  alu_result = alu_in1 & alu_in2;
            OP_OR:   alu_result = alu_in1 | alu_in2;
            OP_XOR:  alu_result = alu_in1 ^ alu_in2;
            default: alu_result = '0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every completed response handshake
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL rsp_unexpected: got id=%0d data=0x%0h expected none",
                         rsp_id, rsp_data);
            end else begin
                rsp_t e;
                e = sb_q.pop_front();
                check("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
                check("rsp_data", rsp_data, e.data);
            end
        end
    end

    // Grant logger and mutual-exclusion watch
    always @(negedge clk) begin
        if (req0_ready && req1_ready) both_ready_cnt++;
        if (req0_ready) begin
            gnt_id_q.push_back(0);
            gnt_cyc_q.push_back(cyc);
        end
        if (req1_ready) begin
            gnt_id_q.push_back(1);
            gnt_cyc_q.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Bounded wait for the given requester's ready; returns sitting at that negedge
    task automatic wait_ready(input int id, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got no ready within 20 cycles expected ready", name);
        end
    endtask

    initial begin
        int grants;
        int exp_ids[4];
        rsp_t e;

        n_err = 0; n_chk = 0; cyc = 0; both_ready_cnt = 0;
        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 0; req0_rd1 = '0; req0_rd2 = '0; req0_simm = '0; req0_imm_sel = 0;
        req0_op = '0;
        req1_valid = 0; req1_rd1 = '0; req1_rd2 = '0; req1_simm = '0; req1_imm_sel = 0;
        req1_op = '0;

        // Reset state
        idle_cycles(2);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_alu_in1", alu_in1, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        rst_n = 1'b1;
        idle_cycles(2);

        // Single immediate op: 5 + 0xFFFFFFFE = 3
        req0_valid = 1; req0_rd1 = 32'd5; req0_simm = 32'hFFFF_FFFE; req0_imm_sel = 1;
        req0_rd2 = 32'd77; req0_op = OP_ADD;
        sb_q.push_back('{id: 1'b0, data: 32'd3});
        wait_ready(0, "t1_req0_ready");
        check("t1_req1_ready", {31'd0, req1_ready}, 32'd0);
        step();
        req0_valid = 0;
        @(negedge clk);
        check("t1_alu_in1", alu_in1, 32'd5);
        check("t1_alu_in2", alu_in2, 32'hFFFF_FFFE);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_rsp_valid_exec", {31'd0, rsp_valid}, 32'd0);
        step();
        @(negedge clk);
        check("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("t1_rsp_data", rsp_data, 32'd3);
        idle_cycles(3);

        // Register operand select on requester 1: 7 + 9 = 16
        req1_valid = 1; req1_rd1 = 32'd7; req1_rd2 = 32'd9; req1_simm = 32'd100;
        req1_imm_sel = 0; req1_op = OP_ADD;
        sb_q.push_back('{id: 1'b1, data: 32'd16});
        wait_ready(1, "t2_req1_ready");
        step();
        req1_valid = 0;
        @(negedge clk);
        check("t2_alu_in2", alu_in2, 32'd9);
        idle_cycles(4);

        // Contention: 0 always computes 10-3=7, 1 computes 0xF0|0x0F=0xFF
        req0_rd1 = 32'd10; req0_rd2 = 32'd3; req0_imm_sel = 0; req0_op = OP_SUB;
        req1_rd1 = 32'hF0; req1_simm = 32'h0F; req1_imm_sel = 1; req1_op = OP_OR;
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_ids = '{0, 0, 0, 0};
`else
        exp_ids = '{0, 1, 0, 1};
`endif
        for (int i = 0; i < 4; i++) begin
            e.id   = exp_ids[i][0];
            e.data = (exp_ids[i] == 0) ? 32'd7 : 32'hFF;
            sb_q.push_back(e);
        end
        gnt_id_q.delete();
        gnt_cyc_q.delete();
        req0_valid = 1; req1_valid = 1;
        grants = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) grants++;
            if (grants == 4) break;
            @(posedge clk);
            #1;
        end
        step();
        req0_valid = 0; req1_valid = 0;
        check("t3_grant_count", gnt_id_q.size(), 32'd4);
        if (gnt_id_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("t3_grant%0d_id", i), gnt_id_q[i], exp_ids[i]);
                if (i > 0) check($sformatf("t3_grant%0d_gap", i),
                                 gnt_cyc_q[i] - gnt_cyc_q[i-1], 32'd3);
            end
        end
        idle_cycles(5);

        // Backpressure: req0 0x12^0x34=0x26 waits; req1 0x100-1=0xFF queued behind it
        rsp_ready = 0;
        req0_rd1 = 32'h12; req0_rd2 = 32'h34; req0_imm_sel = 0; req0_op = OP_XOR;
        req1_rd1 = 32'h100; req1_simm = 32'h1; req1_imm_sel = 1; req1_op = OP_SUB;
        sb_q.push_back('{id: 1'b0, data: 32'h26});
        sb_q.push_back('{id: 1'b1, data: 32'hFF});
        req0_valid = 1; req1_valid = 1;
        wait_ready(0, "t4_req0_ready");
        check("t4_req1_not_ready", {31'd0, req1_ready}, 32'd0);
        step();
        req0_valid = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("t4_hold_data", rsp_data, 32'h26);
            check("t4_hold_id", {31'd0, rsp_id}, 32'd0);
            check("t4_req1_blocked", {31'd0, req1_ready}, 32'd0);
            step();
        end
        rsp_ready = 1;
        step();
        @(negedge clk);
        check("t4_req1_grant_after_hs", {31'd0, req1_ready}, 32'd1);
        step();
        req1_valid = 0;
        idle_cycles(4);

        // Operand stability: rd1 changes right after grant; 0x55+1=0x56
        req0_rd1 = 32'h55; req0_rd2 = 32'h1; req0_imm_sel = 0; req0_op = OP_ADD;
        sb_q.push_back('{id: 1'b0, data: 32'h56});
        req0_valid = 1;
        wait_ready(0, "t5_req0_ready");
        step();
        req0_valid = 0;
        req0_rd1 = 32'hAA;
        @(negedge clk);
        check("t5_alu_in1", alu_in1, 32'h55);
        idle_cycles(4);

        // Reset during EXEC: no response for the aborted op
        req1_rd1 = 32'h9; req1_rd2 = 32'h4; req1_imm_sel = 0; req1_op = OP_ADD;
        req1_valid = 1;
        wait_ready(1, "t6_req1_ready");
        step();
        req1_valid = 0;
        rst_n = 0;
        @(negedge clk);
        check("t6_busy_in_rst", {31'd0, busy}, 32'd0);
        step();
        @(negedge clk);
        check("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("t6_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("t6_rsp_data", rsp_data, 32'd0);
        check("t6_alu_in1", alu_in1, 32'd0);
        check("t6_alu_in2", alu_in2, 32'd0);
        check("t6_alu_op", {28'd0, alu_op}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        step();
        rst_n = 1;
        req0_rd1 = 32'd1; req0_simm = 32'd2; req0_imm_sel = 1; req0_op = OP_ADD;
        sb_q.push_back('{id: 1'b0, data: 32'd3});
        req0_valid = 1; req1_valid = 1;
        @(negedge clk);
        check("t6_first_grant_r0", {31'd0, req0_ready}, 32'd1);
        check("t6_first_grant_r1", {31'd0, req1_ready}, 32'd0);
        step();
        req0_valid = 0; req1_valid = 0;
        idle_cycles(6);

        check("sb_drained", sb_q.size(), 32'd0);
        check("never_both_ready", both_ready_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
